// File: rtl/regbank_wb_scheduler_if.sv
// regbank_wb_scheduler_if: commit-request, load-tracking and bank-drive signals of the write-port scheduler.
interface regbank_wb_scheduler_if;
   logic       alu_valid;
   logic [3:0] alu_rd;
   logic       alu_ready;
   logic       step_valid;
   logic       step_ready;
   logic       load_issue;
   logic [3:0] load_rd;
   logic       load_done;
   logic       load_full;
   logic       irq_req;
   logic       irq_ack;
   logic       eret;
   logic       sp_reset_req;
   logic [3:0] rd_a;
   logic [3:0] rd_b;
   logic       stall;
   logic [2:0] bank_control;
   logic [3:0] bank_regd;
   logic       bank_enable;
   logic       priv;
   modport master (
      output alu_valid, alu_rd, step_valid, load_issue, load_rd, load_done,
             irq_req, eret, sp_reset_req, rd_a, rd_b,
      input  alu_ready, step_ready, load_full, irq_ack, stall,
             bank_control, bank_regd, bank_enable, priv
   );
   modport slave (
      input  alu_valid, alu_rd, step_valid, load_issue, load_rd, load_done,
             irq_req, eret, sp_reset_req, rd_a, rd_b,
      output alu_ready, step_ready, load_full, irq_ack, stall,
             bank_control, bank_regd, bank_enable, priv
   );
endinterface

// File: rtl/regbank_wb_scheduler.sv
// regbank_wb_scheduler: single-port commit arbiter and load-hazard tracker for the banked register file.
// Defining REGBANK_WB_PERF_EN adds saturating stall_cycles / preempt_cycles counters.
module regbank_wb_scheduler #(
   parameter int LOAD_DEPTH = 4,
   parameter int PTR_W      = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   regbank_wb_scheduler_if.slave  bus
`ifdef REGBANK_WB_PERF_EN
   ,
   output logic [15:0]            stall_cycles,
   output logic [15:0]            preempt_cycles
`endif
);
   typedef enum logic [1:0] {S_IDLE, S_IRQ_LR, S_IRQ_SP} state_t;
   state_t           r_state, w_next;
   logic [3:0]       r_mem [LOAD_DEPTH];
   logic [PTR_W-1:0] r_rp, r_wp;
   logic [PTR_W:0]   r_cnt;
   logic             r_priv;
   logic             w_load_g, w_fsm_g, w_sp_g, w_alu_g, w_step_g, w_push, w_full, w_hit;

   always_ff @(posedge clock)
      if (reset) r_state <= S_IDLE;
      else r_state <= w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (bus.irq_req && !r_priv) w_next = S_IRQ_LR;
         S_IRQ_LR: if (w_fsm_g) w_next = S_IRQ_SP;
         default:  if (w_fsm_g) w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_full           = r_cnt == (PTR_W+1)'(LOAD_DEPTH);
      w_load_g         = bus.load_done && r_cnt != '0;
      w_fsm_g          = !w_load_g && r_state != S_IDLE;
      w_sp_g           = !w_load_g && r_state == S_IDLE && bus.sp_reset_req;
      w_alu_g          = !w_load_g && !w_fsm_g && !w_sp_g && bus.alu_valid;
      w_step_g         = !w_load_g && !w_fsm_g && !w_sp_g && !bus.alu_valid && bus.step_valid;
      bus.bank_enable  = w_load_g || w_fsm_g || w_sp_g || w_alu_g || w_step_g;
      bus.bank_control = w_load_g ? 3'd3 : w_fsm_g ? (r_state == S_IRQ_LR ? 3'd4 : 3'd2) :
                         w_sp_g ? 3'd2 : w_alu_g ? 3'd1 : 3'd0;
      bus.bank_regd    = w_load_g ? r_mem[r_rp] : w_alu_g ? bus.alu_rd : 4'd0;
      bus.alu_ready    = w_alu_g;
      bus.step_ready   = w_step_g;
      bus.irq_ack      = w_fsm_g && r_state == S_IRQ_SP;
      bus.load_full    = w_full;
      bus.priv         = r_priv;
   end

   // Hazard scan over live entries only; R14/R15 are banked/PC and never tracked.
   always_comb begin
      w_hit = 1'b0;
      for (int i = 0; i < LOAD_DEPTH; i++)
         if ({1'b0, PTR_W'(PTR_W'(i) - r_rp)} < r_cnt && r_mem[i] < 4'd14 &&
             (r_mem[i] == bus.rd_a || r_mem[i] == bus.rd_b || (bus.alu_valid && r_mem[i] == bus.alu_rd)))
            w_hit = 1'b1;
      bus.stall = w_hit || w_full;
   end

   assign w_push = bus.load_issue && (!w_full || w_load_g);

   always_ff @(posedge clock)
      if (reset) begin
         r_rp   <= '0;
         r_wp   <= '0;
         r_cnt  <= '0;
         r_priv <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wp] <= bus.load_rd;
            r_wp        <= r_wp + 1'b1;
         end
         if (w_load_g) r_rp <= r_rp + 1'b1;
         r_cnt <= r_cnt + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_load_g);
         if (w_fsm_g && r_state == S_IRQ_SP) r_priv <= 1'b1;
         else if (bus.eret && r_state == S_IDLE) r_priv <= 1'b0;
      end

`ifdef REGBANK_WB_PERF_EN
   always_ff @(posedge clock)
      if (reset) begin
         stall_cycles   <= '0;
         preempt_cycles <= '0;
      end else begin
         if (bus.stall && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 1'b1;
         if (bus.alu_valid && !w_alu_g && preempt_cycles != 16'hFFFF) preempt_cycles <= preempt_cycles + 1'b1;
      end
`endif
endmodule

// File: tb/tb_regbank_wb_scheduler.sv
// tb_regbank_wb_scheduler: directed test-plan sequences plus random traffic, checked by a queue-based scoreboard.
module tb_regbank_wb_scheduler;
   localparam int DEPTH = 4;
   typedef struct packed {
      logic av; logic [3:0] ar; logic sv; logic li; logic [3:0] lr;
      logic ld; logic irq; logic er; logic spr; logic [3:0] ra; logic [3:0] rb;
   } in_t;
   typedef struct packed {
      logic [2:0] ctrl; logic [3:0] regd; logic en; logic ar; logic sr;
      logic full; logic ack; logic stall; logic priv;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   exp_t exp_q[$];
   logic [3:0] mq[$];
   int   owed = 0;
   bit   mpriv = 1'b0;
   in_t  s;

   regbank_wb_scheduler_if bus();
`ifdef REGBANK_WB_PERF_EN
   logic [15:0] stall_cycles, preempt_cycles;
`endif
   regbank_wb_scheduler #(.LOAD_DEPTH(DEPTH), .PTR_W(2)) dut (
      .clock(clk), .reset(reset), .bus(bus.slave)
`ifdef REGBANK_WB_PERF_EN
      , .stall_cycles(stall_cycles), .preempt_cycles(preempt_cycles)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [15:0] a, input logic [15:0] x);
      n_chk++;
      if (a !== x) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
      end
   endtask

   // Reference: a load queue, the number of entry writes still owed, and the mode bit.
   task automatic model_commit();
      bit lg, fg, p0;
      int sz;
      sz = mq.size();
      lg = bus.load_done && sz > 0;
      fg = !lg && owed > 0;
      p0 = mpriv;
      if (lg) void'(mq.pop_front());
      if (bus.load_issue && (sz < DEPTH || lg)) mq.push_back(bus.load_rd);
      if (owed == 0) begin
         if (bus.eret) mpriv = 1'b0;
         if (bus.irq_req && !p0) owed = 2;
      end else if (fg) begin
         owed--;
         if (owed == 0) mpriv = 1'b1;
      end
   endtask

   task automatic push_exp();
      exp_t e;
      bit lg, fg, sg, ag, stg, hit;
      lg  = bus.load_done && mq.size() > 0;
      fg  = !lg && owed > 0;
      sg  = !lg && owed == 0 && bus.sp_reset_req;
      ag  = !lg && !fg && !sg && bus.alu_valid;
      stg = !lg && !fg && !sg && !bus.alu_valid && bus.step_valid;
      hit = 1'b0;
      foreach (mq[k])
         if (mq[k] < 14 && (mq[k] == bus.rd_a || mq[k] == bus.rd_b || (bus.alu_valid && mq[k] == bus.alu_rd)))
            hit = 1'b1;
      e.ctrl  = lg ? 3'd3 : fg ? (owed == 2 ? 3'd4 : 3'd2) : sg ? 3'd2 : ag ? 3'd1 : 3'd0;
      e.regd  = lg ? mq[0] : ag ? bus.alu_rd : 4'd0;
      e.en    = lg || fg || sg || ag || stg;
      e.ar    = ag;
      e.sr    = stg;
      e.full  = mq.size() == DEPTH;
      e.ack   = fg && owed == 1;
      e.stall = hit || e.full;
      e.priv  = mpriv;
      exp_q.push_back(e);
   endtask

   task automatic tick(input in_t v);
      @(posedge clk);
      #1;
      if (reset) begin
         mq.delete();
         owed  = 0;
         mpriv = 1'b0;
      end else model_commit();
      bus.alu_valid = v.av;  bus.alu_rd = v.ar;  bus.step_valid = v.sv;
      bus.load_issue = v.li; bus.load_rd = v.lr; bus.load_done = v.ld;
      bus.irq_req = v.irq;   bus.eret = v.er;    bus.sp_reset_req = v.spr;
      bus.rd_a = v.ra;       bus.rd_b = v.rb;
      push_exp();
      #1;
   endtask

   always @(negedge clk)
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("bank_control", 16'(bus.bank_control), 16'(e.ctrl));
         chk("bank_regd",    16'(bus.bank_regd),    16'(e.regd));
         chk("bank_enable",  16'(bus.bank_enable),  16'(e.en));
         chk("alu_ready",    16'(bus.alu_ready),    16'(e.ar));
         chk("step_ready",   16'(bus.step_ready),   16'(e.sr));
         chk("load_full",    16'(bus.load_full),    16'(e.full));
         chk("irq_ack",      16'(bus.irq_ack),      16'(e.ack));
         chk("stall",        16'(bus.stall),        16'(e.stall));
         chk("priv",         16'(bus.priv),         16'(e.priv));
      end

   initial begin
      s = '0;
      tick(s);
      tick(s);
      chk("rst_enable", 16'(bus.bank_enable), 16'd0);
      chk("rst_control", 16'(bus.bank_control), 16'd0);
      chk("rst_stall", 16'(bus.stall), 16'd0);
      chk("rst_full", 16'(bus.load_full), 16'd0);
      chk("rst_priv", 16'(bus.priv), 16'd0);
      reset = 1'b0;
      s = '0; s.av = 1; s.ar = 4'd3; tick(s);
      chk("tp_alu_ctrl", 16'(bus.bank_control), 16'd1);
      chk("tp_alu_regd", 16'(bus.bank_regd), 16'd3);
      chk("tp_alu_ready", 16'(bus.alu_ready), 16'd1);
      s = '0; s.li = 1; s.lr = 4'd5; tick(s);
      s = '0; s.ra = 4'd5; tick(s);
      chk("tp_raw_stall", 16'(bus.stall), 16'd1);
      s.ld = 1; tick(s);
      chk("tp_ld_ctrl", 16'(bus.bank_control), 16'd3);
      chk("tp_ld_regd", 16'(bus.bank_regd), 16'd5);
      chk("tp_pop_stall", 16'(bus.stall), 16'd1);
      s = '0; s.ra = 4'd5; tick(s);
      chk("tp_stall_clear", 16'(bus.stall), 16'd0);
      for (int i = 1; i <= 4; i++) begin
         s = '0; s.li = 1; s.lr = 4'(i); tick(s);
      end
      s = '0; tick(s);
      chk("tp_full", 16'(bus.load_full), 16'd1);
      chk("tp_full_stall", 16'(bus.stall), 16'd1);
      s = '0; s.ld = 1; s.li = 1; s.lr = 4'd6; tick(s);
      chk("tp_wrap_regd", 16'(bus.bank_regd), 16'd1);
      s = '0; tick(s);
      chk("tp_still_full", 16'(bus.load_full), 16'd1);
      for (int i = 0; i < 4; i++) begin
         s = '0; s.ld = 1; tick(s);
         chk("tp_order", 16'(bus.bank_regd), i == 3 ? 16'd6 : 16'(i + 2));
      end
      s = '0; s.irq = 1; tick(s);
      s = '0; tick(s);
      chk("tp_irq_lr", 16'(bus.bank_control), 16'd4);
      tick(s);
      chk("tp_irq_sp", 16'(bus.bank_control), 16'd2);
      chk("tp_irq_ack", 16'(bus.irq_ack), 16'd1);
      tick(s);
      chk("tp_priv_set", 16'(bus.priv), 16'd1);
      s.irq = 1; tick(s);
      s = '0; tick(s);
      chk("tp_irq_ignored", 16'(bus.bank_enable), 16'd0);
      s.er = 1; tick(s);
      s = '0; tick(s);
      chk("tp_eret", 16'(bus.priv), 16'd0);
      s = '0; s.li = 1; s.lr = 4'd7; tick(s);
      s = '0; s.irq = 1; tick(s);
      s = '0; s.ld = 1; tick(s);
      chk("tp_preempt_ld", 16'(bus.bank_control), 16'd3);
      s = '0; tick(s);
      chk("tp_held_lr", 16'(bus.bank_control), 16'd4);
      tick(s);
      chk("tp_after_sp", 16'(bus.bank_control), 16'd2);
      s.er = 1; tick(s);
      reset = 1'b1;
      s = '0; tick(s);
      reset = 1'b0;
      s = '0; s.li = 1; s.lr = 4'd8; tick(s);
      s = '0; s.av = 1; s.ar = 4'd2; s.ld = 1; tick(s);
      chk("tp_alu_deferred", 16'(bus.alu_ready), 16'd0);
      s.ld = 0; tick(s);
      chk("tp_alu_later", 16'(bus.alu_ready), 16'd1);
      s = '0; tick(s);
`ifdef REGBANK_WB_PERF_EN
      chk("tp_preempt_cnt", preempt_cycles, 16'd1);
`endif
      for (int c = 0; c < 2000; c++) begin
         s.av  = $urandom_range(0, 2) == 0;
         s.ar  = 4'($urandom);
         s.sv  = $urandom_range(0, 1) == 0;
         s.li  = $urandom_range(0, 2) == 0;
         s.lr  = 4'($urandom);
         s.ld  = $urandom_range(0, 2) == 0;
         s.irq = $urandom_range(0, 15) == 0;
         s.er  = $urandom_range(0, 15) == 0;
         s.spr = $urandom_range(0, 7) == 0;
         s.ra  = 4'($urandom);
         s.rb  = 4'($urandom);
         tick(s);
      end
      s = '0; tick(s);
      @(negedge clk);
      #1;
      chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/regbank_wb_scheduler.md
Name: regbank_wb_scheduler

Overview:
- Write-port scheduler and hazard tracker in front of the 16-entry register bank with banked SSP/PSP.
- Per cycle, selects one commit source: load return, exception-entry sequence, stack-pointer reset, ALU result or bare PC step.
- Drives the bank's control, RegD, enable and M inputs.
- Tracks in-flight loads in an in-order FIFO and stalls decode on RAW/WAW hazards against pending load destinations.

Parameters:
- LOAD_DEPTH, 4, max outstanding loads; power of two, 2..16.
- PTR_W, 2, log2(LOAD_DEPTH).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result ready to write
- alu_rd  in  4  ALU destination register
- alu_ready  out  1  ALU write granted this cycle
- step_valid  in  1  instruction commits with no register write
- step_ready  out  1  PC-only commit granted
- load_issue  in  1  load request leaves to memory
- load_rd  in  4  load destination register
- load_done  in  1  memory data valid (in order, oldest first)
- load_full  out  1  FIFO holds LOAD_DEPTH entries
- irq_req  in  1  level request for privileged entry
- irq_ack  out  1  one-cycle pulse: entry sequence finished
- eret  in  1  return to user mode
- sp_reset_req  in  1  request to reset current-mode SP and R0
- rd_a, rd_b  in  4 each  source registers of instruction in decode
- stall  out  1  decode must hold
- bank_control  out  3  0 none, 1 Result, 2 SP reset, 3 MemIn, 4 LR<=PC
- bank_regd  out  4  destination register to bank
- bank_enable  out  1  bank commit strobe
- priv  out  1  mode flag to bank M

Behaviour:
- Combinational grant; outputs are valid in the same cycle, and the bank writes at the next edge.
- Fixed priority: load_done > FSM step (IRQ_LR / IRQ_SP) > sp_reset_req > alu_valid > step_valid. Exactly one grant per cycle.
- Any grant sets bank_enable=1. With no grant, bank_enable=0 and bank_control=0.

Load grant:
- Requires load_done=1 and a non-empty FIFO.
- Outputs bank_control=3, bank_regd=FIFO head. The entry pops.
- load_done while the FIFO is empty is ignored and produces no enable.

Load FIFO:
- load_issue pushes load_rd when not full. A push while full is dropped; this cannot occur legally because stall is high.
- Push and pop in the same cycle are both performed.
- Wrap-around uses PTR_W-bit pointers plus a count register.
- load_full=1 when count==LOAD_DEPTH.

Hazards:
- stall=1 if rd_a, rd_b or alu_rd (alu_rd only while alu_valid=1) matches any valid FIFO entry, or if load_full=1.
- Registers 14 and 15 never match.
- A same-cycle pop of the matching entry does not clear stall in that cycle.

ALU grant: bank_control=1, bank_regd=alu_rd. alu_ready=1 only when granted; the requester holds alu_valid until granted.

SP reset grant: bank_control=2, taken only while the FSM is in IDLE.

Step grant: bank_control=0, bank_enable=1, step_ready=1.

Exception FSM:
- IDLE: irq_req=1 and priv=0 -> IRQ_LR.
- IRQ_LR: when granted, bank_control=4 -> IRQ_SP.
- IRQ_SP: when granted, bank_control=2, priv<=1, irq_ack=1 -> IDLE.
- If load_done preempts, the FSM holds its state with no progress.
- irq_req while priv=1 is ignored.
- eret in IDLE clears priv. eret during IRQ_LR or IRQ_SP is ignored.

Reset (synchronous): FIFO empty, FSM IDLE, priv=0. All outputs 0 except stall=0 and load_full=0.

Optional Feature:
- Macro: REGBANK_WB_PERF_EN.
- When defined: adds output stall_cycles[15:0] (counts cycles with stall=1, saturating at 16'hFFFF) and output preempt_cycles[15:0] (counts cycles where alu_valid=1 and the ALU is not granted, saturating). Both clear on reset.
- When undefined: neither port exists and no counter logic is generated.

Test Plan:
- Reset, then alu_valid=1, alu_rd=3 -> same cycle: bank_control=1, bank_regd=3, bank_enable=1, alu_ready=1.
- load_issue with load_rd=5, then rd_a=5 -> stall=1. Later load_done=1 -> bank_control=3, bank_regd=5. The next cycle stall=0.
- Issue 4 loads (rd 1,2,3,4) -> load_full=1, stall=1. Then pop and push in the same cycle -> count stays 4. Returns come back in order 1,2,3,4 across pointer wrap.
- irq_req=1 with priv=0 -> cycle 1: control=4; cycle 2: control=2, irq_ack=1; then priv=1. A second irq_req is ignored. eret -> priv=0.
- irq_req asserted with load_done in the same cycle -> load is granted first (control=3), the FSM holds in IRQ_LR, and control=4 is issued the following cycle.
- alu_valid and load_done together -> ALU is deferred (alu_ready=0) and granted the next cycle. With REGBANK_WB_PERF_EN defined, preempt_cycles=1.
